// File: rtl/sequence_sum_pkg.sv
// rtl/sequence_sum_pkg.sv - shared state encoding and sizing helpers for the sum collector
package sequence_sum_pkg;

  typedef logic [0:0] state_t;
  localparam state_t WARMUP = 1'b0;
  localparam state_t RUN    = 1'b1;

  // Samples to discard before the adder window and its pipeline hold real data.
  function automatic int warmup_len(input int n, input int regs);
    return n + regs;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sequence_sum_collector_if.sv
// rtl/sequence_sum_collector_if.sv - collector stream/status bundle; max_sum only with SUM_COLLECTOR_STATS_EN
interface sequence_sum_collector_if #(
  parameter int data_width = 10,
  parameter int depth      = 8
);
  localparam int CW = $clog2(depth) + 1;

  logic [data_width-1:0] in_data;
  logic                  in_valid;
  logic [data_width-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  overflow;
`ifdef SUM_COLLECTOR_STATS_EN
  logic [data_width-1:0] max_sum;

  modport master (output in_data, in_valid, out_ready,
                  input  out_data, out_valid, count, overflow, max_sum);
  modport slave  (input  in_data, in_valid, out_ready,
                  output out_data, out_valid, count, overflow, max_sum);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  out_data, out_valid, count, overflow);
  modport slave  (input  in_data, in_valid, out_ready,
                  output out_data, out_valid, count, overflow);
`endif
endinterface

// File: rtl/sequence_sum_collector_sum_fifo.sv
// rtl/sequence_sum_collector_sum_fifo.sv - sum_fifo: buffer storage, pointers, occupancy and push/pop arbitration
module sum_fifo
  import sequence_sum_pkg::*;
#(
  parameter int data_width = 10,
  parameter int depth      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push_req,
  input  logic [data_width-1:0]         i_push_data,
  input  logic                          i_pop_req,
  output logic [data_width-1:0]         o_rd_data,
  output logic                          o_rd_valid,
  output logic [$clog2(depth):0]        o_count,
  output logic                          o_push_ok
);
  localparam int PW = ptr_width(depth);
  localparam int CW = $clog2(depth) + 1;

  logic [data_width-1:0] r_mem [depth];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_pop;

  assign w_pop      = i_pop_req && (r_count != '0);
  // Occupancy never exceeds depth, so a full FIFO only accepts when it is popped.
  assign o_push_ok  = i_push_req && ((r_count < CW'(depth)) || w_pop);
  assign o_rd_data  = r_mem[r_rptr];
  assign o_rd_valid = (r_count != '0);
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_push_ok) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({o_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sequence_sum_collector.sv
// rtl/sequence_sum_collector.sv - warm-up discard, overflow flag and buffering of adder sums; peak tracker under SUM_COLLECTOR_STATS_EN
module sequence_sum_collector
  import sequence_sum_pkg::*;
#(
  parameter int data_width = 10,
  parameter int N          = 4,
  parameter int adder_regs = 2,
  parameter int depth      = 8
) (
  input logic                    clk,
  input logic                    rst,
  sequence_sum_collector_if.slave bus
);
  localparam int W   = warmup_len(N, adder_regs);
  localparam int WCW = $clog2(W + 1);

  state_t                  r_state;
  logic [WCW-1:0]          r_wcnt;
  logic                    r_overflow;
  logic                    w_push_req;
  logic                    w_push_ok;
  logic [data_width-1:0]   w_rd_data;
  logic                    w_rd_valid;
  logic [$clog2(depth):0]  w_count;

  assign w_push_req = (r_state == RUN) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WARMUP;
      r_wcnt  <= '0;
    end else if (r_state == WARMUP && bus.in_valid) begin
      // The W-th warm-up sample is discarded too; buffering starts with the next one.
      if (r_wcnt == WCW'(W - 1)) r_state <= RUN;
      else                       r_wcnt  <= r_wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_overflow <= 1'b0;
    else if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
  end

  sum_fifo #(.data_width(data_width), .depth(depth)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_req (w_push_req),
    .i_push_data(bus.in_data),
    .i_pop_req  (bus.out_ready),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid),
    .o_count    (w_count),
    .o_push_ok  (w_push_ok)
  );

  assign bus.out_data  = w_rd_data;
  assign bus.out_valid = w_rd_valid;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;

`ifdef SUM_COLLECTOR_STATS_EN
  logic [data_width-1:0] r_max_sum;

  always_ff @(posedge clk) begin
    if (rst)                                    r_max_sum <= '0;
    else if (w_push_ok && bus.in_data > r_max_sum) r_max_sum <= bus.in_data;
  end

  assign bus.max_sum = r_max_sum;
`endif
endmodule
